// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder
// Description : Memory-side responder for the instruction-fetch read port.
//               Models a backing instruction memory. The first word of a
//               16-byte line costs FIRST_LATENCY cycles. Further words of the
//               same open line are returned one per cycle. A write-only
//               preload port fills the array.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_responder #(
  parameter int          MEM_WORDS     = 4096,
  parameter int          ADDR_BITS     = 12,
  parameter int          FIRST_LATENCY = 4,
  parameter logic [31:0] NOP_WORD      = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_en,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_ACCESS = 2'd1;
  localparam logic [1:0] C_STREAM = 2'd2;

  // Counter value loaded when a closed-line access starts. The response is
  // issued on the edge where the counter would step from 1 to 0, so the
  // first pulse lands FIRST_LATENCY cycles after the request is first seen.
  localparam logic [3:0] C_CNT_INIT = 4'(FIRST_LATENCY - 1);

  localparam int C_IDX_LSB = 2;
  localparam int C_IDX_MSB = ADDR_BITS + 1;
  localparam int C_HI_LSB  = ADDR_BITS + 2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_req_addr;
  logic [27:0] r_open_line;
  logic        r_line_valid;

  // Backing store; never cleared by reset.
  logic [31:0] r_mem [MEM_WORDS];

  // --------------------------------------------------------------------------
  // Combinational next-state signals
  // --------------------------------------------------------------------------
  logic [1:0]           w_state_nxt;
  logic [3:0]           w_cnt_nxt;
  logic [31:0]          w_req_nxt;
  logic [27:0]          w_line_nxt;
  logic                 w_valid_nxt;
  logic                 w_respond;
  logic [31:0]          w_resp_addr;
  logic                 w_resp_in_range;
  logic [ADDR_BITS-1:0] w_resp_idx;
  logic                 w_load_in_range;
  logic [ADDR_BITS-1:0] w_load_idx;
  logic                 w_load_hits_line;
  logic                 w_req_same_line;
  logic                 w_req_stable;
  logic                 w_unused_bits;

  // Byte-offset bits of the preload address carry no information.
  assign w_unused_bits = ^load_addr[1:0];

  assign w_load_in_range = (load_addr[31:C_HI_LSB] == '0);
  assign w_load_idx      = load_addr[C_IDX_MSB:C_IDX_LSB];

  // A preload into the currently open line invalidates it so that later
  // reads pay the full access latency and observe the new contents.
  assign w_load_hits_line = load_en && r_line_valid &&
                            (load_addr[31:4] == r_open_line);

  assign w_req_same_line = (mem_addr[31:4] == r_open_line);
  assign w_req_stable    = mem_read_en && (mem_addr == r_req_addr);

  assign w_resp_in_range = (w_resp_addr[31:C_HI_LSB] == '0);
  assign w_resp_idx      = w_resp_addr[C_IDX_MSB:C_IDX_LSB];

  assign busy = (r_state != C_IDLE);

  // Request sequencing: decide next state and whether a response fires on
  // the coming edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req_addr;
    w_line_nxt  = r_open_line;
    w_valid_nxt = r_line_valid;
    w_respond   = 1'b0;
    w_resp_addr = r_req_addr;

    case (r_state)
      C_IDLE: begin
        if (mem_read_en) begin
          w_req_nxt = mem_addr;
          if (FIRST_LATENCY == 1) begin
            // Single-cycle memory: answer on the very next edge.
            w_respond   = 1'b1;
            w_resp_addr = mem_addr;
            w_line_nxt  = mem_addr[31:4];
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = C_STREAM;
          end else begin
            w_cnt_nxt   = C_CNT_INIT;
            w_state_nxt = C_ACCESS;
          end
        end
      end

      C_ACCESS: begin
        if (!w_req_stable) begin
          // Requester withdrew or changed the request: abort silently.
          w_cnt_nxt   = 4'd0;
          w_valid_nxt = 1'b0;
          w_state_nxt = C_IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_respond   = 1'b1;
          w_resp_addr = r_req_addr;
          w_line_nxt  = r_req_addr[31:4];
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = C_STREAM;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      C_STREAM: begin
        if (!mem_read_en) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = C_IDLE;
        end else if (w_load_hits_line || !w_req_same_line) begin
          // Line closed (new line or overwritten): restart a full access
          // counted from this cycle.
          w_valid_nxt = 1'b0;
          w_req_nxt   = mem_addr;
          if ((FIRST_LATENCY == 1) && !w_load_hits_line) begin
            w_respond   = 1'b1;
            w_resp_addr = mem_addr;
            w_line_nxt  = mem_addr[31:4];
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = 4'd0;
          end else begin
            // After an overwrite the read must land on a later edge than
            // the write, so even a single-cycle memory goes through ACCESS.
            w_cnt_nxt   = C_CNT_INIT;
            w_state_nxt = C_ACCESS;
          end
        end else begin
          // Open-line hit (including a repeat of the same word).
          w_respond   = 1'b1;
          w_resp_addr = mem_addr;
          w_req_nxt   = mem_addr;
        end
      end

      default: begin
        w_cnt_nxt   = 4'd0;
        w_valid_nxt = 1'b0;
        w_state_nxt = C_IDLE;
      end
    endcase
  end

  // Control registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= C_IDLE;
      r_cnt        <= 4'd0;
      r_req_addr   <= '0;
      r_open_line  <= '0;
      r_line_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_req_addr   <= w_req_nxt;
      r_open_line  <= w_line_nxt;
      r_line_valid <= w_valid_nxt;
    end
  end

  // Registered response; array read uses the pre-edge contents, so a
  // preload on the same edge is not visible to this read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= w_respond;
      mem_err   <= w_respond && !w_resp_in_range;
      if (w_respond) begin
        mem_rdata <= w_resp_in_range ? r_mem[w_resp_idx] : NOP_WORD;
      end
    end
  end

  // Preload write port, active in any state; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (load_en && w_load_in_range) begin
      r_mem[w_load_idx] <= load_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_responder
// Description : Self-checking bench for imem_responder. A reference model
//               tracks memory contents and the open line and predicts the
//               latency and data of every read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

  localparam int          MEM_WORDS     = 4096;
  localparam int          ADDR_BITS     = 12;
  localparam int          FIRST_LATENCY = 4;
  localparam logic [31:0] NOP_WORD      = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;
  logic        busy;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  always #5 clk = ~clk;

  imem_responder #(
    .MEM_WORDS    (MEM_WORDS),
    .ADDR_BITS    (ADDR_BITS),
    .FIRST_LATENCY(FIRST_LATENCY),
    .NOP_WORD     (NOP_WORD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read_en(mem_read_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_err    (mem_err),
    .busy       (busy),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory contents plus the currently open line.
  logic [31:0] ref_mem [MEM_WORDS];
  logic        open_valid;
  logic [27:0] open_line;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return (a[31:ADDR_BITS+2] == '0);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (!in_range(a)) return NOP_WORD;
    return ref_mem[a[ADDR_BITS+1:2]];
  endfunction

  task automatic ref_load(input logic [31:0] a, input logic [31:0] d);
    if (in_range(a)) ref_mem[a[ADDR_BITS+1:2]] = d;
    if (open_valid && (a[31:4] == open_line)) open_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Preload one word with no read request active.
  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    mem_read_en = 1'b0;
    load_en     = 1'b1;
    load_addr   = a;
    load_data   = d;
    step();
    load_en    = 1'b0;
    ref_load(a, d);
    open_valid = 1'b0;
    check("load_no_ready", 32'(mem_ready), 32'd0);
  endtask

  // Present a read (optionally with a simultaneous preload) in the current
  // cycle and follow it up to its response pulse. Returns in the pulse cycle.
  task automatic do_read(input logic [31:0] a, input logic ld,
                         input logic [31:0] la, input logic [31:0] ldat);
    int          lat;
    logic [31:0] exp_data;
    mem_read_en = 1'b1;
    mem_addr    = a;
    if (ld) begin
      load_en   = 1'b1;
      load_addr = la;
      load_data = ldat;
      ref_load(la, ldat);
    end
    lat      = (open_valid && (a[31:4] == open_line)) ? 1 : FIRST_LATENCY;
    exp_data = ref_read(a);
    for (int k = 1; k <= lat; k++) begin
      step();
      load_en = 1'b0;
      if (k < lat) begin
        check("wait_ready", 32'(mem_ready), 32'd0);
      end else begin
        check("ready", 32'(mem_ready), 32'd1);
      end
      check("busy_during_read", 32'(busy), 32'd1);
    end
    check("rdata", mem_rdata, exp_data);
    check("err", 32'(mem_err), 32'(!in_range(a)));
    open_valid = 1'b1;
    open_line  = a[31:4];
  endtask

  task automatic do_drop();
    mem_read_en = 1'b0;
    step();
    open_valid = 1'b0;
    check("drop_ready", 32'(mem_ready), 32'd0);
    check("drop_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] pool [4];
  logic [31:0] base;
  logic [31:0] a;
  logic [31:0] la;
  logic        ld;
  int          nburst;

  initial begin
    reset       = 1'b1;
    mem_read_en = 1'b0;
    mem_addr    = '0;
    load_en     = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    open_valid  = 1'b0;
    open_line   = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();

    // Preload line 0x10 and a few neighbours.
    for (int i = 0; i < 4; i++) do_load(32'h10 + 32'(4 * i), 32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++) do_load(32'h20 + 32'(4 * i), $urandom);

    // Closed-line read, then stream the rest of the line back-to-back.
    do_read(32'h10, 1'b0, '0, '0);
    do_read(32'h14, 1'b0, '0, '0);
    do_read(32'h18, 1'b0, '0, '0);
    do_read(32'h1C, 1'b0, '0, '0);
    // Different line directly from the stream: full latency again.
    do_read(32'h20, 1'b0, '0, '0);
    do_drop();

    // Abort mid-access: no response, back to idle.
    mem_read_en = 1'b1;
    mem_addr    = 32'h24;
    step();
    check("abort_wait1", 32'(mem_ready), 32'd0);
    step();
    check("abort_wait2", 32'(mem_ready), 32'd0);
    do_drop();
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_quiet", 32'(mem_ready), 32'd0);
    end

    // Out-of-range read returns the NOP word with an error pulse.
    do_read(32'h0000_4000, 1'b0, '0, '0);
    do_drop();

    // Out-of-range preload aliasing word 0x14 must be dropped.
    do_load(32'h0000_4014, 32'hDEAD_BEEF);
    do_read(32'h14, 1'b0, '0, '0);
    do_drop();

    // Preload into the open line closes it: full-latency re-access.
    do_read(32'h10, 1'b0, '0, '0);
    do_read(32'h14, 1'b1, 32'h14, 32'h0000_BEEF);
    check("beef_value", mem_rdata, 32'h0000_BEEF);
    // Preload elsewhere keeps the line open; repeated word is legal.
    do_read(32'h18, 1'b1, 32'h28, $urandom);
    do_read(32'h18, 1'b0, '0, '0);
    do_drop();

    // Asynchronous reset during an access at counter value 2.
    mem_read_en = 1'b1;
    mem_addr    = 32'h1C;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("arst_ready", 32'(mem_ready), 32'd0);
    check("arst_err", 32'(mem_err), 32'd0);
    check("arst_rdata", mem_rdata, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    mem_read_en = 1'b0;
    step();
    reset      = 1'b0;
    open_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_quiet", 32'(mem_ready), 32'd0);
      check("post_rst_idle", 32'(busy), 32'd0);
    end
    do_read(32'h1C, 1'b0, '0, '0);
    do_drop();

    // Randomized bursts over a small pool of preloaded lines.
    for (int p = 0; p < 4; p++) begin
      pool[p] = {18'd0, 10'($urandom_range(0, 1023)), 4'd0};
      for (int w = 0; w < 4; w++) do_load(pool[p] + 32'(4 * w), $urandom);
    end
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        base = 32'h0001_0000 | ($urandom & 32'h0000_FFF0);
      end else begin
        base = pool[$urandom_range(0, 3)];
      end
      nburst = $urandom_range(1, 5);
      for (int j = 0; j < nburst; j++) begin
        a  = base | 32'($urandom_range(0, 3) << 2) | 32'($urandom_range(0, 3));
        ld = ($urandom_range(0, 3) == 0);
        la = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3) << 2);
        do_read(a, ld, la, $urandom);
      end
      if ($urandom_range(0, 1) == 1) do_drop();
    end
    do_drop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
